// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb : round-robin arbiter/sequencer sharing one ALU between two ports
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_nzcv
);

  localparam logic [OP_W-1:0] OP_ADDS = OP_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   cur_id;
  logic   grant_valid;
  logic   grant_id;
  logic   fire;
  logic   is_adds;

  // Under contention the port that did not win last time goes next.
  assign grant_valid = req0_valid | req1_valid;
  assign grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready  = (state == IDLE) && grant_valid && !grant_id;
  assign req1_ready  = (state == IDLE) && grant_valid && grant_id;
  assign fire        = (state == IDLE) && grant_valid;
  assign is_adds     = (alu_ctrl == OP_ADDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_nzcv   <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            alu_a      <= grant_id ? req1_a  : req0_a;
            alu_b      <= grant_id ? req1_b  : req0_b;
            alu_ctrl   <= grant_id ? req1_op : req0_op;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_nzcv   <= {alu_result[DATA_W-1], (alu_result == '0),
                         is_adds & alu_carry, is_adds & alu_ovf};
          rsp_id     <= cur_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
